jtag_tap_model: RTL

- Cycle-accurate behavioural JTAG TAP for Verilator simulation of the Arty-A7 SoC; the parametrised successor to the constant-tied boundary-scan stub.
- Implements the IEEE 1149.1 16-state TAP controller, an instruction register, IDCODE and BYPASS registers, and NUM_CHAINS user-chain select/handshake outputs with BSCANE2-compatible semantics.
- A testbench can drive TMS/TDI and exercise debug-module DR chains end-to-end.

---
 rtl/jtag_pkg.sv | 29 ++
 rtl/jtag_tap_fsm.sv | 59 +++++
 rtl/jtag_tap_model.sv | 127 ++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared TAP state encoding and default opcodes for the JTAG TAP model
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'd0,
        RTI    = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SH_DR  = 4'd4,
        EX1_DR = 4'd5,
        PA_DR  = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SH_IR  = 4'd11,
        EX1_IR = 4'd12,
        PA_IR  = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } tap_state_e;

    localparam logic [5:0]       IR_BYPASS      = 6'h3F;
    // Index 0 is the leftmost entry: USER1 = 6'h02
    localparam logic [0:3][5:0]  DEF_USER_IR    = {6'h02, 6'h03, 6'h22, 6'h23};
    localparam logic [5:0]       DEF_IDCODE_IR  = 6'h09;
    localparam logic [31:0]      DEF_IDCODE_VAL = 32'h13631093;

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - 16-state IEEE 1149.1 TAP controller with state decodes
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tms_i,
    output tap_state_e state_o,
    output tap_state_e state_next_o,
    output logic       capture_o,
    output logic       shift_o,
    output logic       update_o,
    output logic       reset_o,
    output logic       runtest_o
);

    tap_state_e state_q;
    tap_state_e state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:    state_d = tms_i ? TLR    : RTI;
            RTI:    state_d = tms_i ? SEL_DR : RTI;
            SEL_DR: state_d = tms_i ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms_i ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms_i ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms_i ? UPD_DR : PA_DR;
            PA_DR:  state_d = tms_i ? EX2_DR : PA_DR;
            EX2_DR: state_d = tms_i ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms_i ? SEL_DR : RTI;
            SEL_IR: state_d = tms_i ? TLR    : CAP_IR;
            CAP_IR: state_d = tms_i ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms_i ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms_i ? UPD_IR : PA_IR;
            PA_IR:  state_d = tms_i ? EX2_IR : PA_IR;
            EX2_IR: state_d = tms_i ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms_i ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    assign state_o      = state_q;
    assign state_next_o = state_d;
    assign capture_o    = (state_q == CAP_DR);
    assign shift_o      = (state_q == SH_DR);
    assign update_o     = (state_q == UPD_DR);
    assign reset_o      = (state_q == TLR);
    assign runtest_o    = (state_q == RTI);

endmodule

// File: rtl/jtag_tap_model.sv
// rtl/jtag_tap_model.sv - behavioural JTAG TAP with IR, BYPASS, user chains; IDCODE under JTAG_TAP_IDCODE_EN
module jtag_tap_model
    import jtag_pkg::*;
#(
    parameter int                          IR_LEN     = 6,
    parameter int                          NUM_CHAINS = 4,
    parameter logic [0:3][IR_LEN-1:0]      USER_IR    = DEF_USER_IR,
    parameter logic [IR_LEN-1:0]           IDCODE_IR  = DEF_IDCODE_IR,
    parameter logic [31:0]                 IDCODE_VAL = DEF_IDCODE_VAL
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  tms_i,
    input  logic                  tdi_i,
    output logic                  tdo_o,
    input  logic [NUM_CHAINS-1:0] chain_tdo_i,
    output logic [NUM_CHAINS-1:0] sel_o,
    output logic                  capture_o,
    output logic                  shift_o,
    output logic                  update_o,
    output logic                  reset_o,
    output logic                  runtest_o,
    output logic                  drck_en_o,
    output logic                  tdi_o,
    output logic                  tms_o
);

`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_LEN-1:0] IR_RESET = IDCODE_IR;
`else
    localparam logic [IR_LEN-1:0] IR_RESET = '1;
`endif
    localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(1);

    tap_state_e            state;
    tap_state_e            state_next;
    logic [IR_LEN-1:0]     ir_q;
    logic [IR_LEN-1:0]     ir_sr;
    logic                  bypass_q;
    logic [NUM_CHAINS-1:0] user_hit;
    logic                  idcode_hit;

    jtag_tap_fsm u_fsm (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .tms_i        (tms_i),
        .state_o      (state),
        .state_next_o (state_next),
        .capture_o    (capture_o),
        .shift_o      (shift_o),
        .update_o     (update_o),
        .reset_o      (reset_o),
        .runtest_o    (runtest_o)
    );

    // IR reloads on the edge that enters TLR so the reset opcode is live during TLR itself
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ir_q     <= IR_RESET;
            ir_sr    <= '0;
            bypass_q <= 1'b0;
        end else begin
            if (state_next == TLR) begin
                ir_q <= IR_RESET;
            end else if (state == UPD_IR) begin
                ir_q <= ir_sr;
            end
            case (state)
                CAP_IR:  ir_sr    <= IR_CAPTURE;
                SH_IR:   ir_sr    <= {tdi_i, ir_sr[IR_LEN-1:1]};
                CAP_DR:  bypass_q <= 1'b0;
                SH_DR:   bypass_q <= tdi_i;
                default: ;
            endcase
        end
    end

`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0] idcode_sr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idcode_sr <= '0;
        end else if (state == CAP_DR) begin
            idcode_sr <= IDCODE_VAL;
        end else if (state == SH_DR) begin
            idcode_sr <= {tdi_i, idcode_sr[31:1]};
        end
    end

    assign idcode_hit = (ir_q == IDCODE_IR);
`else
    logic unused_params;
    assign unused_params = ^{IDCODE_IR, IDCODE_VAL};
    assign idcode_hit    = 1'b0;
`endif

    for (genvar k = 0; k < NUM_CHAINS; k++) begin : g_user_hit
        assign user_hit[k] = (ir_q == USER_IR[k]);
    end

    // Isolate the lowest matching chain; an IDCODE match overrides every user opcode
    assign sel_o = idcode_hit ? '0 : (user_hit & (~user_hit + NUM_CHAINS'(1)));

    always_comb begin
        tdo_o = 1'b0;
        if (state == SH_IR) begin
            tdo_o = ir_sr[0];
        end else if (state == SH_DR) begin
            if (|sel_o) begin
                tdo_o = |(sel_o & chain_tdo_i);
            end else begin
                tdo_o = bypass_q;
            end
`ifdef JTAG_TAP_IDCODE_EN
            if (idcode_hit) begin
                tdo_o = idcode_sr[0];
            end
`endif
        end
    end

    assign drck_en_o = (|sel_o) & (capture_o | shift_o);
    assign tdi_o     = tdi_i;
    assign tms_o     = tms_i;

endmodule
